// File: rtl/memory_stage.sv
// memory_stage: single-access data-memory stage between execute and writeback.
// Byte-lane extraction and sign/zero extension of load data happen here.
module memory_stage #(
  localparam int ADDR_WIDTH = 32,
  localparam int DATA_WIDTH = 32,
  localparam int REGISTER_INDEXING_WIDTH = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic                               stall_prev,
  input  logic                               prev_done,
  input  logic                               next_stall,
  output logic                               done_next,
  input  logic [ADDR_WIDTH-1:0]              program_count_in,
  input  logic                               load_in,
  input  logic                               store_in,
  input  logic [2:0]                         funct_3_in,
  input  logic [DATA_WIDTH-1:0]              result_data_in,
  input  logic                               result_data_valid_in,
  input  logic [DATA_WIDTH-1:0]              memory_store_data_in,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register_in,
  input  logic                               write_register_valid_in,
  output logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  output logic [ADDR_WIDTH-1:0]              mem_req_addr,
  output logic                               mem_req_write,
  output logic [DATA_WIDTH-1:0]              mem_req_wdata,
  output logic [3:0]                         mem_req_wstrb,
  input  logic                               mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]              mem_resp_rdata,
  output logic [ADDR_WIDTH-1:0]              program_count_out,
  output logic [REGISTER_INDEXING_WIDTH-1:0] write_register_out,
  output logic                               write_register_valid_out,
  output logic [DATA_WIDTH-1:0]              result_data_out,
  output logic                               result_data_valid_out,
  output logic                               misaligned_out,
  output logic                               illegal_width_out
);

  typedef enum logic [1:0] {EMPTY, REQ, WAIT, FULL} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]              pc;
    logic                               load;
    logic                               store;
    logic [2:0]                         funct3;
    logic [DATA_WIDTH-1:0]              result;
    logic                               result_valid;
    logic [DATA_WIDTH-1:0]              sdata;
    logic [REGISTER_INDEXING_WIDTH-1:0] rd;
    logic                               rd_valid;
    logic                               misaligned;
    logic                               illegal;
  } held_t;

  state_t state, state_nxt;
  held_t  held, cap;

  logic transfer_prev, transfer_next;
  logic is_mem, legal, mis, go_req;
  logic [DATA_WIDTH-1:0] sh, ld_val, wdata;
  logic [3:0] wstrb;

  assign done_next     = (state == FULL);
  assign transfer_next = done_next && !next_stall;
  assign stall_prev    = !rst_n || (state == REQ) || (state == WAIT)
                       || ((state == FULL) && !transfer_next);
  assign transfer_prev = prev_done && !stall_prev;

  // Classify the incoming instruction before it is registered.
  always_comb begin
    is_mem = load_in || store_in;
    legal  = 1'b0;
    mis    = 1'b0;
    if (load_in)
      legal = funct_3_in inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    else if (store_in)
      legal = funct_3_in inside {3'd0, 3'd1, 3'd2};
    unique case (1'b1)
      funct_3_in[1:0] == 2'd1: mis = result_data_in[0];
      funct_3_in[1:0] == 2'd2: mis = |result_data_in[1:0];
      default:                 mis = 1'b0;
    endcase
    go_req = is_mem && legal && !mis && result_data_valid_in;
    cap.pc           = program_count_in;
    cap.load         = load_in;
    cap.store        = store_in;
    cap.funct3       = funct_3_in;
    cap.result       = result_data_in;
    cap.result_valid = result_data_valid_in;
    cap.sdata        = memory_store_data_in;
    cap.rd           = write_register_in;
    cap.misaligned   = is_mem && legal && mis;
    cap.illegal      = is_mem && !legal;
    cap.rd_valid     = write_register_valid_in
                     && !cap.misaligned && !cap.illegal;
  end

  always_comb begin
    sh     = mem_resp_rdata >> {held.result[1:0], 3'b000};
    ld_val = mem_resp_rdata;
    unique case (1'b1)
      held.funct3 == 3'd0: ld_val = {{24{sh[7]}}, sh[7:0]};
      held.funct3 == 3'd1: ld_val = {{16{sh[15]}}, sh[15:0]};
      held.funct3 == 3'd4: ld_val = {24'd0, sh[7:0]};
      held.funct3 == 3'd5: ld_val = {16'd0, sh[15:0]};
      default:             ld_val = mem_resp_rdata;
    endcase
  end

  always_comb begin
    wdata = held.sdata;
    wstrb = 4'b1111;
    unique case (1'b1)
      held.funct3[1:0] == 2'd0: begin
        wdata = {4{held.sdata[7:0]}};
        wstrb = 4'b0001 << held.result[1:0];
      end
      held.funct3[1:0] == 2'd1: begin
        wdata = {2{held.sdata[15:0]}};
        wstrb = 4'b0011 << held.result[1:0];
      end
      default: begin
        wdata = held.sdata;
        wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (transfer_prev) state_nxt = go_req ? REQ : FULL;
      REQ:   if (mem_req_ready) state_nxt = held.store ? FULL : WAIT;
      WAIT:  if (mem_resp_valid) state_nxt = FULL;
      FULL: begin
        if (transfer_next)
          state_nxt = transfer_prev ? (go_req ? REQ : FULL) : EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held <= '0;
    end else if (transfer_prev) begin
      held <= cap;
    end else if (state == WAIT && mem_resp_valid) begin
      held.result       <= ld_val;
      held.result_valid <= 1'b1;
    end
  end

  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = mem_req_valid ? {held.result[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_req_write = mem_req_valid && held.store;
  assign mem_req_wdata = mem_req_write ? wdata : '0;
  assign mem_req_wstrb = mem_req_write ? wstrb : 4'b0000;

  assign program_count_out        = held.pc;
  assign write_register_out       = held.rd;
  assign write_register_valid_out = held.rd_valid;
  assign result_data_out          = held.result;
  assign result_data_valid_out    = held.result_valid;
  assign misaligned_out           = held.misaligned;
  assign illegal_width_out        = held.illegal;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed vectors with hand-computed expectations
// for pass-through, loads, stores, exceptions, back-pressure and reset.
module tb_memory_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_prev;
  logic        prev_done;
  logic        next_stall;
  logic        done_next;
  logic [31:0] program_count_in;
  logic        load_in;
  logic        store_in;
  logic [2:0]  funct_3_in;
  logic [31:0] result_data_in;
  logic        result_data_valid_in;
  logic [31:0] memory_store_data_in;
  logic [4:0]  write_register_in;
  logic        write_register_valid_in;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_write;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic [31:0] program_count_out;
  logic [4:0]  write_register_out;
  logic        write_register_valid_out;
  logic [31:0] result_data_out;
  logic        result_data_valid_out;
  logic        misaligned_out;
  logic        illegal_width_out;

  int vectors = 0;
  int miscompares = 0;

  memory_stage dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .stall_prev               (stall_prev),
    .prev_done                (prev_done),
    .next_stall               (next_stall),
    .done_next                (done_next),
    .program_count_in         (program_count_in),
    .load_in                  (load_in),
    .store_in                 (store_in),
    .funct_3_in               (funct_3_in),
    .result_data_in           (result_data_in),
    .result_data_valid_in     (result_data_valid_in),
    .memory_store_data_in     (memory_store_data_in),
    .write_register_in        (write_register_in),
    .write_register_valid_in  (write_register_valid_in),
    .mem_req_valid            (mem_req_valid),
    .mem_req_ready            (mem_req_ready),
    .mem_req_addr             (mem_req_addr),
    .mem_req_write            (mem_req_write),
    .mem_req_wdata            (mem_req_wdata),
    .mem_req_wstrb            (mem_req_wstrb),
    .mem_resp_valid           (mem_resp_valid),
    .mem_resp_rdata           (mem_resp_rdata),
    .program_count_out        (program_count_out),
    .write_register_out       (write_register_out),
    .write_register_valid_out (write_register_valid_out),
    .result_data_out          (result_data_out),
    .result_data_valid_out    (result_data_valid_out),
    .misaligned_out           (misaligned_out),
    .illegal_width_out        (illegal_width_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic ld,
                       input logic st, input logic [2:0] f3,
                       input logic [31:0] res, input logic rv,
                       input logic [31:0] sd, input logic [4:0] rd,
                       input logic rdv);
    prev_done               = 1'b1;
    program_count_in        = pc;
    load_in                 = ld;
    store_in                = st;
    funct_3_in              = f3;
    result_data_in          = res;
    result_data_valid_in    = rv;
    memory_store_data_in    = sd;
    write_register_in       = rd;
    write_register_valid_in = rdv;
  endtask

  task automatic load_seq(input logic [31:0] rdata);
    prev_done      = 1'b0;
    mem_req_ready  = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    prev_done = 1'b0;
    next_stall = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    drive(32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0);
    prev_done = 1'b0;

    #3;
    chk("rst_stall_prev", {31'd0, stall_prev}, 32'd1);
    chk("rst_done_next", {31'd0, done_next}, 32'd0);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_wstrb", {28'd0, mem_req_wstrb}, 32'd0);
    chk("rst_result", result_data_out, 32'd0);
    #9 rst_n = 1'b1;
    tick();

    // ALU pass-through, back to back
    drive(32'h100, 1'b0, 1'b0, 3'd0, 32'h11, 1'b1, 32'h0, 5'd1, 1'b1);
    #1 chk("pt_stall_empty", {31'd0, stall_prev}, 32'd0);
    tick();
    drive(32'h104, 1'b0, 1'b0, 3'd0, 32'h22, 1'b1, 32'h0, 5'd2, 1'b1);
    chk("pt1_done", {31'd0, done_next}, 32'd1);
    chk("pt1_result", result_data_out, 32'h11);
    chk("pt1_pc", program_count_out, 32'h100);
    chk("pt1_noreq", {31'd0, mem_req_valid}, 32'd0);
    tick();
    drive(32'h108, 1'b0, 1'b0, 3'd0, 32'h33, 1'b1, 32'h0, 5'd3, 1'b1);
    chk("pt2_done", {31'd0, done_next}, 32'd1);
    chk("pt2_result", result_data_out, 32'h22);
    tick();
    prev_done = 1'b0;
    chk("pt3_done", {31'd0, done_next}, 32'd1);
    chk("pt3_result", result_data_out, 32'h33);
    chk("pt3_rd", {27'd0, write_register_out}, 32'd3);
    chk("pt3_noreq", {31'd0, mem_req_valid}, 32'd0);
    tick();
    chk("pt_drain", {31'd0, done_next}, 32'd0);

    // LB at 0x1003
    drive(32'h200, 1'b1, 1'b0, 3'd0, 32'h1003, 1'b1, 32'h0, 5'd5, 1'b1);
    tick();
    prev_done = 1'b0;
    chk("lb_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("lb_req_addr", mem_req_addr, 32'h1000);
    chk("lb_req_write", {31'd0, mem_req_write}, 32'd0);
    chk("lb_req_wstrb", {28'd0, mem_req_wstrb}, 32'd0);
    chk("lb_stall", {31'd0, stall_prev}, 32'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("lb_wait_noreq", {31'd0, mem_req_valid}, 32'd0);
    chk("lb_wait_done", {31'd0, done_next}, 32'd0);
    chk("lb_wait_stall", {31'd0, stall_prev}, 32'd1);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h80FF_FF7F;
    tick();
    mem_resp_valid = 1'b0;
    chk("lb_done", {31'd0, done_next}, 32'd1);
    chk("lb_result", result_data_out, 32'hFFFF_FF80);
    chk("lb_rdv", {31'd0, write_register_valid_out}, 32'd1);
    chk("lb_rv", {31'd0, result_data_valid_out}, 32'd1);

    drive(32'h204, 1'b1, 1'b0, 3'd4, 32'h1003, 1'b1, 32'h0, 5'd6, 1'b1);
    #1 chk("lbu_capture_ok", {31'd0, stall_prev}, 32'd0);
    tick();
    load_seq(32'h80FF_FF7F);
    chk("lbu_result", result_data_out, 32'h0000_0080);

    drive(32'h208, 1'b1, 1'b0, 3'd5, 32'h1002, 1'b1, 32'h0, 5'd7, 1'b1);
    tick();
    chk("lhu_req_addr", mem_req_addr, 32'h1000);
    load_seq(32'h80FF_FF7F);
    chk("lhu_result", result_data_out, 32'h0000_80FF);
    tick();

    // SH 0xBEEF at 0x2002 with ready held low
    drive(32'h300, 1'b0, 1'b1, 3'd1, 32'h2002, 1'b1, 32'h0000_BEEF,
          5'd0, 1'b0);
    tick();
    prev_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sh_req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("sh_req_addr", mem_req_addr, 32'h2000);
      chk("sh_req_wdata", mem_req_wdata, 32'hBEEF_BEEF);
      chk("sh_req_wstrb", {28'd0, mem_req_wstrb}, 32'hC);
      chk("sh_req_write", {31'd0, mem_req_write}, 32'd1);
      chk("sh_done_low", {31'd0, done_next}, 32'd0);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("sh_done", {31'd0, done_next}, 32'd1);
    chk("sh_result", result_data_out, 32'h2002);
    chk("sh_rdv", {31'd0, write_register_valid_out}, 32'd0);
    chk("sh_req_dropped", {31'd0, mem_req_valid}, 32'd0);
    tick();

    // SB 0xA5 at 0x5001
    drive(32'h304, 1'b0, 1'b1, 3'd0, 32'h5001, 1'b1, 32'h1234_56A5,
          5'd0, 1'b0);
    tick();
    prev_done = 1'b0;
    chk("sb_req_wdata", mem_req_wdata, 32'hA5A5_A5A5);
    chk("sb_req_wstrb", {28'd0, mem_req_wstrb}, 32'h2);
    chk("sb_req_addr", mem_req_addr, 32'h5000);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("sb_done", {31'd0, done_next}, 32'd1);
    tick();

    // misaligned LW, then illegal load width
    drive(32'h400, 1'b1, 1'b0, 3'd2, 32'h3001, 1'b1, 32'h0, 5'd8, 1'b1);
    tick();
    prev_done = 1'b0;
    chk("lw_mis_noreq", {31'd0, mem_req_valid}, 32'd0);
    chk("lw_mis_done", {31'd0, done_next}, 32'd1);
    chk("lw_mis_flag", {31'd0, misaligned_out}, 32'd1);
    chk("lw_mis_illegal", {31'd0, illegal_width_out}, 32'd0);
    chk("lw_mis_rdv", {31'd0, write_register_valid_out}, 32'd0);
    tick();
    drive(32'h404, 1'b1, 1'b0, 3'd3, 32'h3000, 1'b1, 32'h0, 5'd9, 1'b1);
    tick();
    prev_done = 1'b0;
    chk("ill_flag", {31'd0, illegal_width_out}, 32'd1);
    chk("ill_mis", {31'd0, misaligned_out}, 32'd0);
    chk("ill_rdv", {31'd0, write_register_valid_out}, 32'd0);
    chk("ill_noreq", {31'd0, mem_req_valid}, 32'd0);
    tick();

    // invalid address load: no access, result invalid
    drive(32'h408, 1'b1, 1'b0, 3'd2, 32'h3000, 1'b0, 32'h0, 5'd9, 1'b1);
    tick();
    prev_done = 1'b0;
    chk("inv_noreq", {31'd0, mem_req_valid}, 32'd0);
    chk("inv_done", {31'd0, done_next}, 32'd1);
    chk("inv_rv", {31'd0, result_data_valid_out}, 32'd0);
    tick();

    // back-pressure from writeback
    drive(32'h500, 1'b0, 1'b0, 3'd0, 32'hAA, 1'b1, 32'h0, 5'd10, 1'b1);
    tick();
    drive(32'h504, 1'b0, 1'b0, 3'd0, 32'hBB, 1'b1, 32'h0, 5'd11, 1'b1);
    next_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_stall", {31'd0, stall_prev}, 32'd1);
      chk("bp_done", {31'd0, done_next}, 32'd1);
      chk("bp_result", result_data_out, 32'hAA);
      chk("bp_pc", program_count_out, 32'h500);
      tick();
    end
    next_stall = 1'b0;
    #1 chk("bp_release", {31'd0, stall_prev}, 32'd0);
    tick();
    prev_done = 1'b0;
    chk("bp_next_result", result_data_out, 32'hBB);
    chk("bp_next_done", {31'd0, done_next}, 32'd1);
    tick();

    // reset during WAIT, stray response afterwards
    drive(32'h600, 1'b1, 1'b0, 3'd2, 32'h4000, 1'b1, 32'h0, 5'd12, 1'b1);
    tick();
    prev_done = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("rw_in_wait", {31'd0, stall_prev}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rw_done", {31'd0, done_next}, 32'd0);
    chk("rw_stall", {31'd0, stall_prev}, 32'd1);
    tick();
    rst_n = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h1234_5678;
    tick();
    mem_resp_valid = 1'b0;
    chk("rw_stray_done", {31'd0, done_next}, 32'd0);
    chk("rw_stray_result", result_data_out, 32'd0);
    chk("rw_stray_stall", {31'd0, stall_prev}, 32'd0);
    tick();
    chk("rw_idle_done", {31'd0, done_next}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
